// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared definitions for the UART transmit path (and the future
// receiver): FSM state encoding, data-bit count and the clocks-per-bit helper.
// No ports; imported with "import uart_tx_pkg::*;".
package uart_tx_pkg;

    // Frame sequencer states. The encoding is fixed so that debug taps and
    // checkers see stable values.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int UART_DATA_BITS = 8;

    // Integer (truncated) number of clk cycles per serial bit.
    function automatic int calc_clks_per_bit(input int clk_freq_hz, input int baud);
        return clk_freq_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: byte handshake between a producer (CPU side) and the UART
// transmitter.
//   tx_data  [7:0] byte to send, sampled only on the accepting edge
//   tx_valid       producer has a byte; held until accepted
//   tx_ready       transmitter can accept a byte
// Handshake: a byte is transferred on every rising clk edge where
// tx_valid && tx_ready are both high; tx_valid while tx_ready is low is
// ignored (no queueing), so the producer keeps tx_valid/tx_data stable until
// the transfer edge.
// Modports: master = producer, slave = transmitter.
interface uart_tx_if
    import uart_tx_pkg::*;
();
    logic [UART_DATA_BITS-1:0] tx_data;
    logic                      tx_valid;
    logic                      tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_baud_counter.sv
// uart_baud_counter: free-running bit-period counter, 0..CLKS_PER_BIT-1.
//   clk     system clock
//   resetn  synchronous active-low reset (count -> 0)
//   clear   synchronous clear (count -> 0), used to align the counter to the
//           start of a frame
//   tick    high for the one cycle where count == CLKS_PER_BIT-1 (bit boundary)
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    output logic tick
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST);
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter. Accepts one byte per handshake and sends it
// as start bit (0), 8 data bits LSB first, stop bit (1), each bit held for
// CLKS_PER_BIT = CLK_FREQ_HZ/BAUD clocks.
//   clk     system clock
//   resetn  synchronous active-low reset; abandons any frame in flight
//   tx_if   byte handshake (slave side): tx_data, tx_valid, tx_ready
//   txd     serial line, idle high (registered)
//   busy    frame in progress, always !tx_ready (registered)
//   state   current sequencer state, for debug/checkers
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 12000000,
    parameter int BAUD        = 115200
) (
    input  logic       clk,
    input  logic       resetn,
    uart_tx_if.slave   tx_if,
    output logic       txd,
    output logic       busy,
    output state_t     state
);
    localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ_HZ, BAUD);
    localparam int BIT_CNT_W    = $clog2(UART_DATA_BITS);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(UART_DATA_BITS - 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_baud
            $error("uart_tx: CLK_FREQ_HZ/BAUD must be at least 2");
        end
    endgenerate

    logic                      tick;
    logic                      tx_ready_q;
    logic [UART_DATA_BITS-1:0] shift_reg;
    logic [BIT_CNT_W-1:0]      bit_cnt;

    // Holding the counter clear while idle makes the first START cycle count 0,
    // so every bit (including the start bit) lasts exactly CLKS_PER_BIT cycles.
    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .resetn (resetn),
        .clear  (state == IDLE),
        .tick   (tick)
    );

    assign tx_if.tx_ready = tx_ready_q;

    // txd/tx_ready/busy are all updated here alongside the state so that they
    // change on the same edge as the state they belong to.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            txd        <= 1'b1;
            tx_ready_q <= 1'b1;
            busy       <= 1'b0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // tx_ready is always high here, so tx_valid alone accepts.
                    if (tx_if.tx_valid) begin
                        shift_reg  <= tx_if.tx_data;
                        txd        <= 1'b0;
                        tx_ready_q <= 1'b0;
                        busy       <= 1'b1;
                        bit_cnt    <= '0;
                        state      <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        txd   <= shift_reg[0];
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            txd     <= 1'b1;
                            state   <= STOP;
                        end else begin
                            // txd is registered, so present the next bit now.
                            shift_reg <= shift_reg >> 1;
                            txd       <= shift_reg[1];
                            bit_cnt   <= bit_cnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        tx_ready_q <= 1'b1;
                        busy       <= 1'b0;
                        txd        <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx with CLK_FREQ_HZ=40, BAUD=10
// (4 clocks per bit). Inputs change and outputs are sampled on the falling
// clock edge; the DUT acts on the rising edge. Expected line levels come from
// a frame model that expands a byte into start/data/stop levels.
module tb_uart_tx;
    import uart_tx_pkg::*;

    localparam int CPB       = 40 / 10;
    localparam int FRAME_LEN = 10 * CPB;

    logic   clk = 1'b0;
    logic   resetn;
    logic   txd;
    logic   busy;
    state_t state;

    int checks   = 0;
    int failures = 0;

    logic exp_q[$];

    uart_tx_if bus ();

    uart_tx #(
        .CLK_FREQ_HZ (40),
        .BAUD        (10)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .tx_if  (bus),
        .txd    (txd),
        .busy   (busy),
        .state  (state)
    );

    always #5 clk = ~clk;

    // Reference model: the line levels of one 8N1 frame, each held CPB cycles.
    function automatic void model_frame(input logic [7:0] b);
        logic lvl;
        for (int k = 0; k < 10; k++) begin
            if (k == 0)      lvl = 1'b0;
            else if (k == 9) lvl = 1'b1;
            else             lvl = b[k-1];
            for (int c = 0; c < CPB; c++) exp_q.push_back(lvl);
        end
    endfunction

    task automatic test_reset();
        resetn       = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (txd !== 1'b1 || bus.tx_ready !== 1'b1 || busy !== 1'b0 || state !== IDLE) begin
                failures++;
                $display("FAIL reset_idle cyc %0d: txd=%b ready=%b busy=%b state=%0d, need 1 1 0 0",
                         i, txd, bus.tx_ready, busy, state);
            end
        end
    endtask

    task automatic test_single_frame();
        exp_q.delete();
        model_frame(8'h55);
        bus.tx_data  = 8'h55;
        bus.tx_valid = 1'b1;
        for (int i = 0; i < FRAME_LEN; i++) begin
            @(negedge clk);
            if (i == 0) bus.tx_valid = 1'b0;
            checks++;
            if (txd !== exp_q[0] || bus.tx_ready !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL single_0x55 cyc %0d: txd=%b ready=%b busy=%b, need txd=%b ready=0 busy=1",
                         i, txd, bus.tx_ready, busy, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
        @(negedge clk);
        checks++;
        if (bus.tx_ready !== 1'b1 || txd !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_ready_back: ready=%b txd=%b busy=%b, need 1 1 0", bus.tx_ready, txd, busy);
        end
    endtask

    task automatic test_back_to_back();
        exp_q.delete();
        model_frame(8'hA3);
        bus.tx_data  = 8'hA3;
        bus.tx_valid = 1'b1;
        for (int i = 0; i < FRAME_LEN; i++) begin
            @(negedge clk);
            if (i == 0) bus.tx_data = 8'h0F;
            checks++;
            if (txd !== exp_q[0] || bus.tx_ready !== 1'b0) begin
                failures++;
                $display("FAIL b2b_0xA3 cyc %0d: txd=%b ready=%b, need txd=%b ready=0",
                         i, txd, bus.tx_ready, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
        // The single idle-high gap; tx_valid is still high, so the next edge accepts.
        @(negedge clk);
        checks++;
        if (txd !== 1'b1 || bus.tx_ready !== 1'b1 || state !== IDLE) begin
            failures++;
            $display("FAIL b2b_gap: txd=%b ready=%b state=%0d, need 1 1 0", txd, bus.tx_ready, state);
        end
        model_frame(8'h0F);
        for (int i = 0; i < FRAME_LEN; i++) begin
            @(negedge clk);
            if (i == 0) bus.tx_valid = 1'b0;
            checks++;
            if (txd !== exp_q[0] || bus.tx_ready !== 1'b0) begin
                failures++;
                $display("FAIL b2b_0x0F cyc %0d: txd=%b ready=%b, need txd=%b ready=0",
                         i, txd, bus.tx_ready, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
        @(negedge clk);
        checks++;
        if (bus.tx_ready !== 1'b1 || txd !== 1'b1) begin
            failures++;
            $display("FAIL b2b_end: ready=%b txd=%b, need 1 1", bus.tx_ready, txd);
        end
    endtask

    task automatic test_data_stable();
        exp_q.delete();
        model_frame(8'h00);
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b1;
        for (int i = 0; i < FRAME_LEN; i++) begin
            @(negedge clk);
            if (i == 0)  begin bus.tx_valid = 1'b0; bus.tx_data = 8'hFF; end
            if (i == 15) bus.tx_valid = 1'b1;
            if (i == 16) bus.tx_valid = 1'b0;
            checks++;
            if (txd !== exp_q[0]) begin
                failures++;
                $display("FAIL hold_0x00 cyc %0d: txd=%b need %b", i, txd, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (txd !== 1'b1 || bus.tx_ready !== 1'b1 || state !== IDLE) begin
                failures++;
                $display("FAIL ignored_pulse cyc %0d: txd=%b ready=%b state=%0d, need 1 1 0",
                         i, txd, bus.tx_ready, state);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        exp_q.delete();
        model_frame(8'hFF);
        bus.tx_data  = 8'hFF;
        bus.tx_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 0) bus.tx_valid = 1'b0;
            checks++;
            if (txd !== exp_q[0] || bus.tx_ready !== 1'b0) begin
                failures++;
                $display("FAIL pre_reset_0xFF cyc %0d: txd=%b ready=%b, need txd=%b ready=0",
                         i, txd, bus.tx_ready, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        checks++;
        if (txd !== 1'b1 || bus.tx_ready !== 1'b1 || busy !== 1'b0 || state !== IDLE) begin
            failures++;
            $display("FAIL mid_frame_reset: txd=%b ready=%b busy=%b state=%0d, need 1 1 0 0",
                     txd, bus.tx_ready, busy, state);
        end
        resetn = 1'b1;
        @(negedge clk);
        exp_q.delete();
        model_frame(8'h81);
        bus.tx_data  = 8'h81;
        bus.tx_valid = 1'b1;
        for (int i = 0; i < FRAME_LEN; i++) begin
            @(negedge clk);
            if (i == 0) bus.tx_valid = 1'b0;
            checks++;
            if (txd !== exp_q[0]) begin
                failures++;
                $display("FAIL after_reset_0x81 cyc %0d: txd=%b need %b", i, txd, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
        @(negedge clk);
        checks++;
        if (bus.tx_ready !== 1'b1 || txd !== 1'b1) begin
            failures++;
            $display("FAIL after_reset_end: ready=%b txd=%b, need 1 1", bus.tx_ready, txd);
        end
    endtask

    task automatic test_reset_vs_valid();
        bus.tx_data  = 8'h42;
        bus.tx_valid = 1'b1;
        resetn       = 1'b0;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        resetn       = 1'b1;
        checks++;
        if (txd !== 1'b1 || bus.tx_ready !== 1'b1 || state !== IDLE) begin
            failures++;
            $display("FAIL reset_wins: txd=%b ready=%b state=%0d, need 1 1 0", txd, bus.tx_ready, state);
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++;
            if (txd !== 1'b1 || state !== IDLE) begin
                failures++;
                $display("FAIL no_frame_0x42 cyc %0d: txd=%b state=%0d, need 1 0", i, txd, state);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        int         w;
        for (int n = 0; n < 6; n++) begin
            w = 0;
            while (bus.tx_ready !== 1'b1 && w < 100) begin
                @(negedge clk);
                w++;
            end
            checks++;
            if (bus.tx_ready !== 1'b1) begin
                failures++;
                $display("FAIL rand_wait_ready frame %0d: ready=%b need 1", n, bus.tx_ready);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            b = 8'($urandom_range(0, 255));
            exp_q.delete();
            model_frame(b);
            bus.tx_data  = b;
            bus.tx_valid = 1'b1;
            for (int i = 0; i < FRAME_LEN; i++) begin
                @(negedge clk);
                if (i == 0) bus.tx_valid = 1'b0;
                if (i == 3) bus.tx_data = 8'($urandom_range(0, 255));
                checks++;
                if (txd !== exp_q[0] || busy !== 1'b1) begin
                    failures++;
                    $display("FAIL rand_0x%02h cyc %0d: txd=%b busy=%b, need txd=%b busy=1",
                             b, i, txd, busy, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_data_stable();
        test_reset_mid_frame();
        test_reset_vs_valid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
